pipe_cla_adder: RTL

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/pipe_cla_adder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder: segment k of the operands is summed in stage k and
// all result bits leave together. Define CLA_SUBTRACT_EN to honour the sub input (a - b).
module pipe_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SEG = WIDTH / STAGES;

  // Parallel-prefix g/p tree over one segment; returns {carry_out, sum}.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] g_nxt;
    logic [SEG-1:0] p_nxt;
    logic [SEG:0]   c;
    g = x & y;
    p = x | y;
    for (int d = 1; d < SEG; d = d * 2) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = d; i < SEG; i++) begin
        g_nxt[i] = g[i] | (p[i] & g[i-d]);
        p_nxt[i] = p[i] & p[i-d];
      end
      g = g_nxt;
      p = p_nxt;
    end
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & ci);
    end
    return {c[SEG], x ^ y ^ c[SEG-1:0]};
  endfunction

  logic [WIDTH-1:0] b_op;
  logic             cin_op;
  logic             advance;

`ifdef CLA_SUBTRACT_EN
  assign b_op   = b ^ {WIDTH{sub}};
  assign cin_op = c_in | sub;
`else
  logic unused_sub;
  assign b_op       = b;
  assign cin_op     = c_in;
  assign unused_sub = sub;
`endif

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG;
    localparam int DONE = (k + 1) * SEG;

    logic [WIDTH-LO-1:0] op_a;
    logic [WIDTH-LO-1:0] op_b;
    logic                ci;
    logic                v_in;
    logic [SEG:0]        seg_res;
    logic [DONE-1:0]     sum_nxt;
    logic                valid_r;
    logic                carry_r;
    logic [DONE-1:0]     sum_r;

    if (k == 0) begin : g_head
      assign op_a    = a;
      assign op_b    = b_op;
      assign ci      = cin_op;
      assign v_in    = in_valid;
      assign seg_res = cla_seg(op_a[SEG-1:0], op_b[SEG-1:0], ci);
      assign sum_nxt = seg_res[SEG-1:0];
    end else begin : g_link
      assign op_a    = g_stage[k-1].g_skew.a_r;
      assign op_b    = g_stage[k-1].g_skew.b_r;
      assign ci      = g_stage[k-1].carry_r;
      assign v_in    = g_stage[k-1].valid_r;
      assign seg_res = cla_seg(op_a[SEG-1:0], op_b[SEG-1:0], ci);
      assign sum_nxt = {seg_res[SEG-1:0], g_stage[k-1].sum_r};
    end

    // Stage valid, segment carry and accumulated low result bits.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= {DONE{1'b0}};
      end else if (advance) begin
        valid_r <= v_in;
        carry_r <= seg_res[SEG];
        sum_r   <= sum_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-DONE-1:0] a_r;
      logic [WIDTH-DONE-1:0] b_r;

      // Operand segments not yet summed wait here for their carry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= {(WIDTH-DONE){1'b0}};
          b_r <= {(WIDTH-DONE){1'b0}};
        end else if (advance) begin
          a_r <= op_a[WIDTH-LO-1:SEG];
          b_r <= op_b[WIDTH-LO-1:SEG];
        end
      end
    end else begin : g_tail
      logic ovf_r;

      // Carry into the MSB is recovered as s ^ a ^ b at that bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (advance) begin
          ovf_r <= seg_res[SEG] ^ seg_res[SEG-1] ^ op_a[SEG-1] ^ op_b[SEG-1];
        end
      end
    end
  end

  assign s         = g_stage[STAGES-1].sum_r;
  assign c_out     = g_stage[STAGES-1].carry_r;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_r;
  assign out_valid = g_stage[STAGES-1].valid_r;

endmodule
